// File: rtl/dataint_chksum_pkg.sv
// Shared types for the multi-channel checksum engine: algorithm encoding and
// the decode of the raw 2-bit mode input.
package dataint_chksum_pkg;

    typedef enum logic [1:0] {
        CHK_SUM  = 2'd0,
        CHK_ONES = 2'd1,
        CHK_XOR  = 2'd2
    } chksum_mode_t;

    // The reserved encoding 3 behaves exactly like the plain modulo sum.
    function automatic chksum_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return CHK_ONES;
            2'd2:    return CHK_XOR;
            default: return CHK_SUM;
        endcase
    endfunction

endpackage

// File: rtl/dataint_chksum_lane.sv
// One channel's running accumulator and saturating beat counter. Publishes the
// would-be next sum and count so the top can capture them on a frame's last beat.
module dataint_chksum_lane
    import dataint_chksum_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic               i_last,
    input  chksum_mode_t       i_mode,
    input  logic [WIDTH-1:0]   i_data,
    output logic [WIDTH-1:0]   o_next,
    output logic [COUNT_W-1:0] o_count_next
);

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    // A single end-around fold suffices: acc + data <= 2^(W+1)-2, so the
    // folded value never carries out again.
    function automatic logic [WIDTH-1:0] chksum_step(input chksum_mode_t mode,
                                                     input logic [WIDTH-1:0] acc,
                                                     input logic [WIDTH-1:0] data);
        logic [WIDTH:0] s;
        s = {1'b0, acc} + {1'b0, data};
        case (mode)
            CHK_ONES: return s[WIDTH-1:0] + WIDTH'(s[WIDTH]);
            CHK_XOR:  return acc ^ data;
            default:  return s[WIDTH-1:0];
        endcase
    endfunction

    always_comb begin
        o_next       = chksum_step(i_mode, acc_q, i_data);
        o_count_next = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        if (i_clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (i_accept) begin
            acc_d = i_last ? '0 : o_next;
            cnt_d = i_last ? '0 : o_count_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dataint_checksum_mc.sv
// Multi-channel frame checksum engine: per-channel lanes, channel decode and a
// one-slot valid/ready result register that can drain and reload in one cycle.
module dataint_checksum_mc
    import dataint_chksum_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int COUNT_W   = 16,
    parameter int INVERT_OC = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic [1:0]         i_mode,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [CH_W-1:0]    i_chan,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_last,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [WIDTH-1:0]   o_res_chksum,
    output logic [CH_W-1:0]    o_res_chan,
    output logic [COUNT_W-1:0] o_res_count,
    output logic               o_err_chan
);

    // Handshakes: a beat transfers on i_valid & o_ready and a result on
    // o_res_valid & i_res_ready; a held result stalls every channel.
    chksum_mode_t       mode;
    logic               beat_acc;
    logic               chan_valid;
    logic               load;
    logic [CHANNELS-1:0] lane_accept;
    logic [WIDTH-1:0]   lane_next [CHANNELS];
    logic [COUNT_W-1:0] lane_cnt  [CHANNELS];
    logic [WIDTH-1:0]   sel_next;
    logic [COUNT_W-1:0] sel_cnt;

    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_chksum_q, res_chksum_d;
    logic [CH_W-1:0]    res_chan_q, res_chan_d;
    logic [COUNT_W-1:0] res_count_q, res_count_d;
    logic               err_chan_q, err_chan_d;

    assign mode       = decode_mode(i_mode);
    assign o_ready    = !res_valid_q || i_res_ready;
    assign beat_acc   = i_valid && o_ready;
    assign chan_valid = (CH_W+1)'(i_chan) < (CH_W+1)'(CHANNELS);
    assign load       = beat_acc && chan_valid && i_last && !i_clear;

    always_comb begin
        lane_accept = '0;
        sel_next    = '0;
        sel_cnt     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_chan == CH_W'(i)) begin
                lane_accept[i] = beat_acc;
                sel_next       = lane_next[i];
                sel_cnt        = lane_cnt[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        dataint_chksum_lane #(
            .WIDTH   (WIDTH),
            .COUNT_W (COUNT_W)
        ) u_lane (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_clear      (i_clear),
            .i_accept     (lane_accept[g]),
            .i_last       (i_last),
            .i_mode       (mode),
            .i_data       (i_data),
            .o_next       (lane_next[g]),
            .o_count_next (lane_cnt[g])
        );
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_chksum_d = res_chksum_q;
        res_chan_d   = res_chan_q;
        res_count_d  = res_count_q;
        err_chan_d   = beat_acc && !chan_valid && !i_clear;
        if (load) begin
            res_valid_d  = 1'b1;
            res_chksum_d = (mode == CHK_ONES && INVERT_OC != 0) ? ~sel_next : sel_next;
            res_chan_d   = i_chan;
            res_count_d  = sel_cnt;
        end else if (i_res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_valid_q  <= 1'b0;
            res_chksum_q <= '0;
            res_chan_q   <= '0;
            res_count_q  <= '0;
            err_chan_q   <= 1'b0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_chksum_q <= res_chksum_d;
            res_chan_q   <= res_chan_d;
            res_count_q  <= res_count_d;
            err_chan_q   <= err_chan_d;
        end
    end

    assign o_res_valid  = res_valid_q;
    assign o_res_chksum = res_chksum_q;
    assign o_res_chan   = res_chan_q;
    assign o_res_count  = res_count_q;
    assign o_err_chan   = err_chan_q;

endmodule

// File: tb/tb_dataint_checksum_mc.sv
// Directed bench: a 4-channel engine and a 3-channel engine share stimulus and
// take turns in reset; each is checked against hand-computed results.
module tb_dataint_checksum_mc;

  logic        clk;
  logic        rst_a_n, rst_b_n;
  logic        clear, valid, last, res_ready;
  logic [1:0]  mode, chan;
  logic [15:0] data;

  logic        a_ready, a_res_valid, a_err;
  logic [15:0] a_chksum, a_count;
  logic [1:0]  a_chan;
  logic        b_ready, b_res_valid, b_err;
  logic [15:0] b_chksum, b_count;
  logic [1:0]  b_chan;

  int checks;
  int failures;

  dataint_checksum_mc #(.WIDTH(16), .CHANNELS(4), .COUNT_W(16), .INVERT_OC(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_clear(clear), .i_mode(mode),
    .i_valid(valid), .o_ready(a_ready), .i_chan(chan), .i_data(data), .i_last(last),
    .o_res_valid(a_res_valid), .i_res_ready(res_ready), .o_res_chksum(a_chksum),
    .o_res_chan(a_chan), .o_res_count(a_count), .o_err_chan(a_err)
  );

  dataint_checksum_mc #(.WIDTH(16), .CHANNELS(3), .COUNT_W(16), .INVERT_OC(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .i_clear(clear), .i_mode(mode),
    .i_valid(valid), .o_ready(b_ready), .i_chan(chan), .i_data(data), .i_last(last),
    .o_res_valid(b_res_valid), .i_res_ready(res_ready), .o_res_chksum(b_chksum),
    .o_res_chan(b_chan), .o_res_count(b_count), .o_err_chan(b_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input bit use_b, input logic v,
                         input logic [15:0] sum, input logic [1:0] ch, input logic [15:0] cnt);
    chk_eq({tag, "_valid"}, use_b ? b_res_valid : a_res_valid, v);
    chk_eq({tag, "_chksum"}, use_b ? b_chksum : a_chksum, sum);
    chk_eq({tag, "_chan"}, use_b ? b_chan : a_chan, ch);
    chk_eq({tag, "_count"}, use_b ? b_count : a_count, cnt);
  endtask

  // driver: called at a falling edge, returns at the falling edge after acceptance
  task automatic drive_beat(input logic [1:0] c, input logic [15:0] d, input logic l,
                            input logic [1:0] m, input bit use_b);
    int n;
    chan  = c;
    data  = d;
    last  = l;
    mode  = m;
    valid = 1'b1;
    #1;
    n = 0;
    while (!(use_b ? b_ready : a_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq("ready_wait", (n < 20), 1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    clear = 1'b0; valid = 1'b0; last = 1'b0; res_ready = 1'b1;
    mode = 2'd0; chan = 2'd0; data = 16'h0;

    #3;
    chk_res("reset", 0, 1'b0, 16'h0, 2'd0, 16'd0);
    chk_eq("reset_err", a_err, 0);
    chk_eq("reset_ready", a_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);

    // mode 0 with wrap, then a fresh frame proves acc0 restarted from zero
    drive_beat(2'd0, 16'hFFFF, 1'b0, 2'd0, 0);
    drive_beat(2'd0, 16'h0002, 1'b0, 2'd0, 0);
    drive_beat(2'd0, 16'h0003, 1'b1, 2'd0, 0);
    chk_res("sum3", 0, 1'b1, 16'h0004, 2'd0, 16'd3);
    drive_beat(2'd0, 16'h0005, 1'b1, 2'd0, 0);
    chk_res("sum_restart", 0, 1'b1, 16'h0005, 2'd0, 16'd1);

    // ones-complement with end-around carry and inversion
    drive_beat(2'd1, 16'hFFFF, 1'b0, 2'd1, 0);
    drive_beat(2'd1, 16'h0002, 1'b1, 2'd1, 0);
    chk_res("ones2", 0, 1'b1, 16'hFFFD, 2'd1, 16'd2);
    drive_beat(2'd1, 16'h0000, 1'b1, 2'd1, 0);
    chk_res("ones_zero", 0, 1'b1, 16'hFFFF, 2'd1, 16'd1);

    // reserved mode 3 behaves as modulo sum
    drive_beat(2'd0, 16'h8000, 1'b0, 2'd3, 0);
    drive_beat(2'd0, 16'h8001, 1'b1, 2'd3, 0);
    chk_res("mode3", 0, 1'b1, 16'h0001, 2'd0, 16'd2);

    // XOR, interleaved channels 2 and 3
    drive_beat(2'd2, 16'h00F0, 1'b0, 2'd2, 0);
    drive_beat(2'd3, 16'h1234, 1'b0, 2'd2, 0);
    drive_beat(2'd2, 16'h0F00, 1'b1, 2'd2, 0);
    chk_res("xor_ch2", 0, 1'b1, 16'h0FF0, 2'd2, 16'd2);
    drive_beat(2'd3, 16'h1234, 1'b1, 2'd2, 0);
    chk_res("xor_ch3", 0, 1'b1, 16'h0000, 2'd3, 16'd2);
    @(negedge clk);

    // backpressure holds the result and stalls input
    res_ready = 1'b0;
    drive_beat(2'd1, 16'h1111, 1'b1, 2'd0, 0);
    chk_res("bp_load", 0, 1'b1, 16'h1111, 2'd1, 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("bp_ready", a_ready, 0);
      chk_res("bp_hold", 0, 1'b1, 16'h1111, 2'd1, 16'd1);
    end
    res_ready = 1'b1;
    drive_beat(2'd2, 16'h2222, 1'b1, 2'd0, 0);
    chk_res("b2b_reload", 0, 1'b1, 16'h2222, 2'd2, 16'd1);
    @(negedge clk);
    chk_res("drain_keep", 0, 1'b0, 16'h2222, 2'd2, 16'd1);

    // clear wins over a last beat; the pending ch1 result drains intact
    drive_beat(2'd0, 16'h0101, 1'b0, 2'd0, 0);
    drive_beat(2'd0, 16'h0202, 1'b0, 2'd0, 0);
    res_ready = 1'b0;
    drive_beat(2'd1, 16'h00AA, 1'b1, 2'd0, 0);
    chk_res("clr_pending", 0, 1'b1, 16'h00AA, 2'd1, 16'd1);
    res_ready = 1'b1;
    clear = 1'b1;
    drive_beat(2'd0, 16'h0303, 1'b1, 2'd0, 0);
    clear = 1'b0;
    chk_res("clr_noresult", 0, 1'b0, 16'h00AA, 2'd1, 16'd1);
    drive_beat(2'd0, 16'h0007, 1'b1, 2'd0, 0);
    chk_res("clr_acc0", 0, 1'b1, 16'h0007, 2'd0, 16'd1);
    @(negedge clk);

    // three-channel engine: invalid channel and reset mid-frame
    rst_a_n = 1'b0;
    rst_b_n = 1'b1;
    @(negedge clk);
    drive_beat(2'd0, 16'h0010, 1'b0, 2'd0, 1);
    drive_beat(2'd3, 16'h5555, 1'b1, 2'd0, 1);
    chk_eq("err_pulse", b_err, 1);
    chk_eq("err_noresult", b_res_valid, 0);
    @(negedge clk);
    chk_eq("err_drop", b_err, 0);
    drive_beat(2'd0, 16'h0001, 1'b1, 2'd0, 1);
    chk_res("err_acc0", 1, 1'b1, 16'h0011, 2'd0, 16'd2);
    drive_beat(2'd1, 16'h0100, 1'b0, 2'd0, 1);
    res_ready = 1'b0;
    drive_beat(2'd2, 16'h0033, 1'b1, 2'd0, 1);
    chk_res("b_pending", 1, 1'b1, 16'h0033, 2'd2, 16'd1);
    #2;
    rst_b_n = 1'b0;
    #1;
    chk_res("async_rst", 1, 1'b0, 16'h0, 2'd0, 16'd0);
    chk_eq("async_rst_ready", b_ready, 1);
    @(negedge clk);
    rst_b_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_ready", b_ready, 1);
    drive_beat(2'd1, 16'h0002, 1'b1, 2'd0, 1);
    chk_res("post_rst_ch1", 1, 1'b1, 16'h0002, 2'd1, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dataint_checksum_mc.md
Name: dataint_checksum_mc

Overview:
- Multi-channel, frame-aware checksum engine, generalised from the single-accumulator running checksum.
- Accumulates beats for up to CHANNELS interleaved streams, one accumulator per channel.
- Three runtime-selectable algorithms: modulo sum, ones-complement with end-around carry, and XOR.
- On each frame's last beat it emits a result through a one-slot valid/ready output with backpressure; sits beside the data-integrity generators/checkers on packet datapaths.

Parameters:
- WIDTH, 16, data and checksum width (>=2).
- CHANNELS, 4, number of independent accumulators (>=1).
- CH_W, $clog2(CHANNELS) min 1, channel index width (derived, localparam).
- COUNT_W, 16, per-channel beat counter width.
- INVERT_OC, 1, 1 = ones-complement mode emits bitwise inverse of sum (Internet checksum).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_clear  in  1  synchronous clear of all accumulators and counters
- i_mode  in  2  0=mod-2^WIDTH sum, 1=ones-complement sum, 2=XOR, 3=reserved (treated as 0)
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid & o_ready
- i_chan  in  CH_W  channel of the beat
- i_data  in  WIDTH  beat data
- i_last  in  1  final beat of frame on i_chan
- o_res_valid  out  1  result slot occupied
- i_res_ready  in  1  downstream accepts result
- o_res_chksum  out  WIDTH  frame checksum
- o_res_chan  out  CH_W  channel of result
- o_res_count  out  COUNT_W  beats in frame, including last
- o_err_chan  out  1  pulse: accepted beat with i_chan >= CHANNELS

Behaviour:
- Reset is i_rst_n, asynchronous, active-low, on clock i_clk.
- Reset values:
  - all accumulators and counters 0;
  - o_res_valid 0, o_res_chksum 0, o_res_chan 0, o_res_count 0, o_err_chan 0;
  - o_ready 1 after reset.
- Accept: a beat is accepted when i_valid & o_ready. o_ready = !o_res_valid | i_res_ready (combinational from i_res_ready only).
- Per accepted beat on channel c, next accumulator value n:
  - mode 0: n = acc[c] + i_data, truncated to WIDTH.
  - mode 1: s = {1'b0,acc[c]} + i_data (WIDTH+1 bits); n = s[WIDTH-1:0] + s[WIDTH]. No second carry is possible.
  - mode 2: n = acc[c] ^ i_data.
- Mode is sampled per beat. Mixing modes inside a frame is legal but undefined in meaning; the bench does not check it.
- Beat counter cnt[c] increments per accepted beat, saturating at 2^COUNT_W-1.
- Non-last beat: acc[c] <= n; cnt[c] <= cnt[c]+1.
- Last beat: result register loads one cycle after accept (o_res_valid rises the next edge):
  - chksum = (mode==1 && INVERT_OC) ? ~n : n;
  - chan = c; count = cnt[c]+1 (saturating).
  - Same edge: acc[c] <= 0, cnt[c] <= 0.
- Result handshake:
  - o_res_valid stays high, and outputs stay stable, until i_res_ready.
  - Result drain and a new last-beat load in the same cycle is legal: the new result replaces the old one, o_res_valid stays 1. Gives back-to-back throughput of one frame per cycle.
  - When o_res_valid & !i_res_ready, o_ready=0 for all beats, last or not. Simple, no per-channel skid.
- Drain with no new last beat: o_res_valid <= 0. Output data regs keep their last value.
- Invalid channel (i_chan >= CHANNELS, only possible when CHANNELS is not a power of 2):
  - beat accepted and dropped, no state change;
  - o_err_chan pulses 1 cycle, registered.
- i_clear: has priority over an accepted beat in the same cycle. The beat is consumed and discarded, a last beat produces no result. A pending result is unaffected.
- Channels fully independent; interleaving beats of different channels is arbitrary.
- Reset mid-frame: all partial sums are lost and no result is produced.

Decomposition:
- Package dataint_chksum_pkg:
  - enum chksum_mode_t {CHK_SUM=2'd0, CHK_ONES=2'd1, CHK_XOR=2'd2};
  - function chksum_step(mode, acc, data) returning n, parameterised via WIDTH in a parameterised class or a local function copy.
- One natural sub-module, dataint_chksum_lane: a single channel's accumulator and counter with accept/last/clear inputs, generated CHANNELS times.
- Top keeps the channel decode, result slot and handshake.

Test Plan:
- Mode 0, ch0, beats 0xFFFF,0x0002,last 0x0003 -> result 0x0004, chan 0, count 3; acc0 back to 0.
- Mode 1, INVERT_OC=1, ch1, beats 0xFFFF,last 0x0002 -> raw 0x0002, result 0xFFFD; mode 1 with single last beat 0x0000 -> 0xFFFF.
- Mode 2, interleaved ch2: 0x00F0, ch3: 0x1234, ch2 last: 0x0F00, ch3 last: 0x1234 -> results in order ch2=0x0FF0 count 2, ch3=0x0000 count 2.
- Backpressure: result pending, i_res_ready=0 for 5 cycles -> o_ready=0, outputs stable. Then i_res_ready=1 with new last beat same cycle -> new result loaded, o_res_valid held 1.
- i_clear asserted with accepted last beat on ch0 after two beats -> no result, acc0/cnt0 = 0, a pending ch1 result is still delivered intact.
- CHANNELS=3, beat with i_chan=3 -> o_err_chan pulses one cycle, all accumulators unchanged. Assert i_rst_n=0 mid-frame -> all outputs 0 asynchronously, o_ready=1 after release.
